dd_scan_controller: RTL and testbench

//  Parametrised multiplexed 7-segment scan driver, next generation of the Dynamic_Display path.

---
 rtl/dd_scan_controller_pkg.sv | 27 ++
 rtl/dd_seg7_decoder.sv | 43 ++++
 rtl/dd_scan_controller.sv | 209 ++++++++++++++++++++
 tb/tb_dd_scan_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/dd_scan_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : dd_scan_controller_pkg
//  Description : Basic types and constants shared by the dynamic display
//                (multiplexed 7-segment) scan path.
//  Contents    : DD_SegPath / DD_NibblePath types, blank segment pattern,
//                decimal-point bit position, default scan geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package dd_scan_controller_pkg;

  // {dp,g,f,e,d,c,b,a}, active-high inside the core
  typedef logic [7:0] DD_SegPath;
  // One hex digit
  typedef logic [3:0] DD_NibblePath;

  localparam DD_SegPath SEG_BLANK  = 8'h00;
  localparam int        SEG_DP_BIT = 7;

  localparam int DEF_COUNT     = 'h3000;
  localparam int LED_OUT_WIDTH = 8;

  localparam int DD_DEF_SCAN_COUNT = DEF_COUNT;
  localparam int DD_NUM_DIGITS     = LED_OUT_WIDTH;

endpackage
`default_nettype wire

// File: rtl/dd_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : dd_seg7_decoder
//  Description : Combinational hex nibble to 7-segment decoder, active-high.
//  Ports       : i_nibble  in  4   hex value 0..F
//                o_seg     out 7   {g,f,e,d,c,b,a}, 1 = segment lit
//  Revision    : 1.0  initial release
// ============================================================================
module dd_seg7_decoder
  import dd_scan_controller_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  DD_NibblePath w_nib;
  assign w_nib = i_nibble;

  always_comb begin
    o_seg = 7'h00;
    case (w_nib)
      4'h0:    o_seg = 7'h3F;
      4'h1:    o_seg = 7'h06;
      4'h2:    o_seg = 7'h5B;
      4'h3:    o_seg = 7'h4F;
      4'h4:    o_seg = 7'h66;
      4'h5:    o_seg = 7'h6D;
      4'h6:    o_seg = 7'h7D;
      4'h7:    o_seg = 7'h07;
      4'h8:    o_seg = 7'h7F;
      4'h9:    o_seg = 7'h6F;
      4'hA:    o_seg = 7'h77;
      4'hB:    o_seg = 7'h7C;
      4'hC:    o_seg = 7'h39;
      4'hD:    o_seg = 7'h5E;
      4'hE:    o_seg = 7'h79;
      4'hF:    o_seg = 7'h71;
      default: o_seg = 7'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : dd_scan_controller
//  Description : Multiplexed 7-segment scan driver. Time-shares one segment
//                bus over NUM_DIGITS gate lines with a per-frame data
//                snapshot, inter-digit blanking, brightness PWM, decimal
//                points, leading-zero suppression and a frame-done strobe.
//  Ports       : clk          in   1              system clock
//                rst          in   1              async reset, active-low
//                enable       in   1              1 = scan, 0 = dark/held
//                digits       in   NUM_DIGITS*4   nibble i at [i*4 +: 4]
//                dpMask       in   NUM_DIGITS     decimal point per digit
//                zeroSuppress in   1              blank leading zeros
//                brightness   in   BRIGHT_WIDTH   0 dimmest, all-ones full
//                seg          out  8              {dp,g..a}, SEG_ACT_LOW pol.
//                gate         out  NUM_DIGITS     one-hot, GATE_ACT_LOW pol.
//                frameDone    out  1              pulse after last slot
//  Revision    : 1.0  initial release
// ============================================================================
module dd_scan_controller
  import dd_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = DD_NUM_DIGITS,
  parameter int SCAN_COUNT   = DD_DEF_SCAN_COUNT,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_WIDTH = 2,
  parameter bit SEG_ACT_LOW  = 1'b1,
  parameter bit GATE_ACT_LOW = 1'b1
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_DIGITS*4-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dpMask,
  input  logic                    zeroSuppress,
  input  logic [BRIGHT_WIDTH-1:0] brightness,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   gate,
  output logic                    frameDone
);

  localparam int c_cw   = $clog2(SCAN_COUNT);
  localparam int c_iw   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int c_step = SCAN_COUNT >> BRIGHT_WIDTH;

  localparam logic [c_cw-1:0]       c_cnt_last = c_cw'(SCAN_COUNT - 1);
  localparam logic [c_iw-1:0]       c_idx_last = c_iw'(NUM_DIGITS - 1);
  localparam logic [c_cw-1:0]       c_blank    = c_cw'(BLANK_CYCLES);
  localparam logic [7:0]            c_seg_off  = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] c_gate_off = GATE_ACT_LOW ? '1 : '0;

  // --------------------------------------------------------------------------
  // Slot counter and digit index
  // --------------------------------------------------------------------------
  logic [c_cw-1:0] r_cnt;
  logic [c_iw-1:0] r_idx;
  logic            r_enable_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_idx      <= '0;
      r_enable_d <= 1'b0;
    end else begin
      r_enable_d <= enable;
      if (!enable) begin
        r_cnt <= '0;
        r_idx <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt <= '0;
        r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_iw'(1);
      end else begin
        r_cnt <= r_cnt + c_cw'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame snapshot. On the capture cycle the incoming values are forwarded so
  // the very first slot position of a frame already shows the new data.
  // --------------------------------------------------------------------------
  logic                    w_capture;
  logic [NUM_DIGITS*4-1:0] r_digits_s;
  logic [NUM_DIGITS-1:0]   r_dp_s;
  logic                    r_zs_s;
  logic [BRIGHT_WIDTH-1:0] r_bright_s;

  assign w_capture = ((r_cnt == '0) && (r_idx == '0)) || (enable && !r_enable_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits_s <= '0;
      r_dp_s     <= '0;
      r_zs_s     <= 1'b0;
      r_bright_s <= '0;
    end else if (w_capture) begin
      r_digits_s <= digits;
      r_dp_s     <= dpMask;
      r_zs_s     <= zeroSuppress;
      r_bright_s <= brightness;
    end
  end

  logic [NUM_DIGITS*4-1:0] w_digits_eff;
  logic [NUM_DIGITS-1:0]   w_dp_eff;
  logic                    w_zs_eff;
  logic [BRIGHT_WIDTH-1:0] w_bright_eff;

  assign w_digits_eff = w_capture ? digits       : r_digits_s;
  assign w_dp_eff     = w_capture ? dpMask       : r_dp_s;
  assign w_zs_eff     = w_capture ? zeroSuppress : r_zs_s;
  assign w_bright_eff = w_capture ? brightness   : r_bright_s;

  // --------------------------------------------------------------------------
  // Leading-zero mask: digit i is blank when it and every digit to its left
  // are zero. The rightmost digit always shows so a value of 0 reads "0".
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] w_suppress;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_supp
    if (gi == 0) begin : g_lsd
      assign w_suppress[gi] = 1'b0;
    end else begin : g_upper
      assign w_suppress[gi] = w_zs_eff && (w_digits_eff[NUM_DIGITS*4-1:gi*4] == '0);
    end
  end

  // --------------------------------------------------------------------------
  // Select the current digit
  // --------------------------------------------------------------------------
  logic [3:0]            w_nib;
  logic                  w_dp_cur;
  logic                  w_supp_cur;
  logic [NUM_DIGITS-1:0] w_gate_hi;

  always_comb begin
    w_nib      = '0;
    w_dp_cur   = 1'b0;
    w_supp_cur = 1'b0;
    w_gate_hi  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == c_iw'(i)) begin
        w_nib        = w_digits_eff[i*4 +: 4];
        w_dp_cur     = w_dp_eff[i];
        w_supp_cur   = w_suppress[i];
        w_gate_hi[i] = 1'b1;
      end
    end
  end

  logic [6:0] w_seg7;

  dd_seg7_decoder u_dec (
    .i_nibble (w_nib),
    .o_seg    (w_seg7)
  );

  DD_SegPath w_seg_hi;

  always_comb begin
    w_seg_hi             = SEG_BLANK;
    w_seg_hi[6:0]        = w_supp_cur ? 7'h00 : w_seg7;
    w_seg_hi[SEG_DP_BIT] = w_dp_cur;
  end

  // --------------------------------------------------------------------------
  // Lit window: dark for the blanking prefix (lets the previous digit's
  // drivers turn off before the next gate opens), then on until the
  // brightness-dependent on-time. The extra bit keeps full brightness
  // (on-time == SCAN_COUNT) representable.
  // --------------------------------------------------------------------------
  logic [BRIGHT_WIDTH:0] w_bright_p1;
  logic [c_cw:0]         w_on_time;
  logic                  w_lit;

  assign w_bright_p1 = {1'b0, w_bright_eff} + {{BRIGHT_WIDTH{1'b0}}, 1'b1};
  assign w_on_time   = (c_cw + 1)'(32'(w_bright_p1) * c_step);

  // A suppressed digit still opens its gate when it has to show a dp.
  assign w_lit = enable
              && (r_cnt >= c_blank)
              && ({1'b0, r_cnt} < w_on_time)
              && (!w_supp_cur || w_dp_cur);

  // --------------------------------------------------------------------------
  // Registered outputs (one cycle behind cnt/idx)
  // --------------------------------------------------------------------------
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_gate;
  logic                  r_frame_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg        <= c_seg_off;
      r_gate       <= c_gate_off;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_lit ? (w_seg_hi ^ c_seg_off)   : c_seg_off;
      r_gate       <= w_lit ? (w_gate_hi ^ c_gate_off) : c_gate_off;
      r_frame_done <= enable && (r_idx == c_idx_last) && (r_cnt == c_cnt_last);
    end
  end

  assign seg       = r_seg;
  assign gate      = r_gate;
  assign frameDone = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_dd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dd_scan_controller
//  Description : Self-checking bench for dd_scan_controller (4 digits,
//                16-cycle slots, 2 blank cycles, active-high outputs).
//                A frame-position reference model predicts seg/gate/frameDone
//                every cycle; directed scenarios are followed by random ones.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dd_scan_controller;

  localparam int ND = 4;
  localparam int SC = 16;
  localparam int BL = 2;
  localparam int BW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  dpMask = '0;
  logic        zeroSuppress = 1'b0;
  logic [1:0]  brightness = '0;
  logic [7:0]  seg;
  logic [3:0]  gate;
  logic        frameDone;

  always #5 clk = ~clk;

  dd_scan_controller #(
    .NUM_DIGITS   (ND),
    .SCAN_COUNT   (SC),
    .BLANK_CYCLES (BL),
    .BRIGHT_WIDTH (BW),
    .SEG_ACT_LOW  (1'b0),
    .GATE_ACT_LOW (1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .digits       (digits),
    .dpMask       (dpMask),
    .zeroSuppress (zeroSuppress),
    .brightness   (brightness),
    .seg          (seg),
    .gate         (gate),
    .frameDone    (frameDone)
  );

  logic [7:0] dec_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int n_checks = 0;
  int n_pass   = 0;
  int lit_cycles = 0;

  // Reference model: position within the frame plus the frame's snapshot
  int          m_pos = 0;
  logic [15:0] m_dig = '0;
  logic [3:0]  m_dp  = '0;
  logic        m_zs  = 1'b0;
  int          m_br  = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_pos = 0;
    m_dig = '0;
    m_dp  = '0;
    m_zs  = 1'b0;
    m_br  = 0;
  endtask

  // One clock: predict, advance the model, clock the DUT, compare.
  task automatic step();
    logic [7:0] e_seg;
    logic [3:0] e_gate;
    logic       e_fd;
    int         slot;
    int         c;
    int         on_t;
    bit         sup;
    bit         dpb;
    e_seg  = '0;
    e_gate = '0;
    e_fd   = 1'b0;
    if (enable) begin
      if (m_pos == 0) begin
        m_dig = digits;
        m_dp  = dpMask;
        m_zs  = zeroSuppress;
        m_br  = int'(brightness);
      end
      slot = m_pos / SC;
      c    = m_pos % SC;
      on_t = (m_br + 1) * (SC >> BW);
      sup  = m_zs && (slot > 0) && ((m_dig >> (slot * 4)) == 16'h0);
      dpb  = m_dp[slot];
      if (c >= BL && c < on_t && (!sup || dpb)) begin
        e_gate = 4'(1 << slot);
        e_seg  = (sup ? 8'h00 : dec_tab[m_dig[slot*4 +: 4]]) | (dpb ? 8'h80 : 8'h00);
      end
      e_fd  = (m_pos == ND * SC - 1);
      m_pos = (m_pos + 1) % (ND * SC);
    end else begin
      m_pos = 0;
    end
    @(posedge clk);
    #1;
    check_value("gate", 32'(gate), 32'(e_gate));
    check_value("seg", 32'(seg), 32'(e_seg));
    check_value("frameDone", 32'(frameDone), 32'(e_fd));
    if (gate != '0) lit_cycles++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    // Reset state
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_seg", 32'(seg), 32'h0);
    check_value("rst_gate", 32'(gate), 32'h0);
    check_value("rst_frameDone", 32'(frameDone), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // 1234 at full brightness: 14 lit cycles per slot
    digits = 16'h1234; dpMask = 4'b0000; zeroSuppress = 1'b0; brightness = 2'd3;
    enable = 1'b1;
    lit_cycles = 0; run(64);
    check_value("lit_b3", 32'(lit_cycles), 32'd56);
    run(64);

    brightness = 2'd0;
    lit_cycles = 0; run(64);
    check_value("lit_b0", 32'(lit_cycles), 32'd8);

    brightness = 2'd1;
    lit_cycles = 0; run(64);
    check_value("lit_b1", 32'(lit_cycles), 32'd24);

    // Leading-zero suppression
    brightness = 2'd3; digits = 16'h0050; zeroSuppress = 1'b1;
    lit_cycles = 0; run(64);
    check_value("lit_zs_0050", 32'(lit_cycles), 32'd28);

    digits = 16'h0000;
    lit_cycles = 0; run(64);
    check_value("lit_zs_0000", 32'(lit_cycles), 32'd14);

    dpMask = 4'b0100;
    lit_cycles = 0; run(64);
    check_value("lit_zs_dp", 32'(lit_cycles), 32'd28);

    // Mid-frame data change is held off until the next frame
    dpMask = 4'b0000; zeroSuppress = 1'b0; digits = 16'h1234;
    run(34);
    digits = 16'hABCD;
    run(30);
    run(64);

    // Enable dropped in slot 2, then re-enabled
    run(36);
    enable = 1'b0;
    run(5);
    enable = 1'b1;
    run(64);

    // Asynchronous reset while a digit is lit
    run(21);
    rst = 1'b0;
    #1;
    check_value("arst_seg", 32'(seg), 32'h0);
    check_value("arst_gate", 32'(gate), 32'h0);
    check_value("arst_frameDone", 32'(frameDone), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    run(64);

    // Randomized traffic
    for (int k = 0; k < 2000; k++) begin
      if (enable && $urandom_range(0, 149) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
      if ($urandom_range(0, 29) == 0) begin
        for (int d = 0; d < ND; d++)
          digits[d*4 +: 4] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 15)) : 4'h0;
        dpMask       = 4'($urandom);
        zeroSuppress = 1'($urandom);
        brightness   = 2'($urandom);
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
